// File: rtl/ctrl_pkg.sv
// Shared opcode/ALUOp encodings and the packed control bundle for the ID-stage decoder.
package ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       alu_src;
      logic       reg_write;
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Only these formats carry a real rs2; others reuse those bits as immediate.
   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BR);
   endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure opcode -> control-bundle table; no state.
// RegWrite is suppressed for rd==x0 so downstream never needs to special-case it.
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter bit ENABLE_JUMP = 1'b1
)(
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t c;

   always_comb begin
      c = '0;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_FUNCT;
         end
         OP_I: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_FUNCT;
         end
         OP_LOAD: begin
            c.alu_src    = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.alu_op     = ALUOP_ADD;
         end
         OP_STORE: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.alu_op    = ALUOP_ADD;
         end
         OP_BR: begin
            c.branch = 1'b1;
            c.alu_op = ALUOP_BR;
         end
         OP_JAL: begin
            if (ENABLE_JUMP) begin
               c.reg_write = 1'b1;
               c.jump      = 1'b1;
            end else begin
               c.illegal = 1'b1;
            end
         end
         OP_JALR: begin
            if (ENABLE_JUMP) begin
               c.alu_src   = 1'b1;
               c.reg_write = 1'b1;
               c.jump      = 1'b1;
            end else begin
               c.illegal = 1'b1;
            end
         end
         default: c.illegal = 1'b1;
      endcase
      if (rd == 5'd0) c.reg_write = 1'b0;
   end

   assign ctrl = c;

endmodule

// File: rtl/ctrl_decode_stage.sv
// RV32I ID stage: decodes control and latches it with operand fields into ID/EX (1-cycle latency).
// Holds while EX is not ready; a load-use pair costs one bubble; flush drops stage and input.
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int PC_W        = 32,
   parameter bit ENABLE_JUMP = 1'b1,
   parameter bit HAZARD_EN   = 1'b1,
   parameter int ILL_CNT_W   = 8
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [31:0]          instr_i,
   input  logic [PC_W-1:0]      pc_i,
   input  logic                 flush_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PC_W-1:0]      pc_o,
   output logic [4:0]           rs1_o,
   output logic [4:0]           rs2_o,
   output logic [4:0]           rd_o,
   output logic [2:0]           funct3_o,
   output logic                 funct7b5_o,
   output logic                 ALUSrc_o,
   output logic                 RegWrite_o,
   output logic                 Branch_o,
   output logic                 Jump_o,
   output logic                 MemRead_o,
   output logic                 MemWrite_o,
   output logic                 MemtoReg_o,
   output logic [1:0]           ALUOp_o,
   output logic                 illegal_o,
   output logic                 stall_o,
   output logic [ILL_CNT_W-1:0] ill_cnt_o
);

   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   ctrl_t      dec;
   ctrl_t      ctrl_q;
   logic       advance;
   logic       hazard;
   logic       unused_instr;

   assign opcode       = instr_i[6:0];
   assign rd           = instr_i[11:7];
   assign rs1          = instr_i[19:15];
   assign rs2          = instr_i[24:20];
   assign unused_instr = &{1'b0, instr_i[31], instr_i[29:25]};

   ctrl_decode_comb #(.ENABLE_JUMP(ENABLE_JUMP)) u_dec (
      .opcode (opcode),
      .rd     (rd),
      .ctrl   (dec)
   );

   assign advance = !out_valid_o || out_ready_i;

   // ctrl_q is cleared whenever the entry goes invalid, so MemRead_o implies a live load.
   assign hazard = HAZARD_EN && in_valid_i && out_valid_o && MemRead_o && (rd_o != 5'd0) &&
                   ((rd_o == rs1) || ((rd_o == rs2) && uses_rs2(opcode)));

   assign in_ready_o = flush_i || (advance && !hazard);
   assign stall_o    = hazard && advance && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         ctrl_q      <= '0;
         pc_o        <= '0;
         rs1_o       <= '0;
         rs2_o       <= '0;
         rd_o        <= '0;
         funct3_o    <= '0;
         funct7b5_o  <= 1'b0;
         ill_cnt_o   <= '0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
         ctrl_q      <= '0;
      end else if (hazard) begin
         if (advance) begin
            out_valid_o <= 1'b0;
            ctrl_q      <= '0;
         end
      end else if (advance) begin
         if (in_valid_i) begin
            out_valid_o <= 1'b1;
            ctrl_q      <= dec;
            pc_o        <= pc_i;
            rs1_o       <= rs1;
            rs2_o       <= rs2;
            rd_o        <= rd;
            funct3_o    <= instr_i[14:12];
            funct7b5_o  <= instr_i[30];
            if (dec.illegal && (ill_cnt_o != {ILL_CNT_W{1'b1}}))
               ill_cnt_o <= ill_cnt_o + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
         end else begin
            out_valid_o <= 1'b0;
            ctrl_q      <= '0;
         end
      end
   end

   assign ALUSrc_o   = ctrl_q.alu_src;
   assign RegWrite_o = ctrl_q.reg_write;
   assign Branch_o   = ctrl_q.branch;
   assign Jump_o     = ctrl_q.jump;
   assign MemRead_o  = ctrl_q.mem_read;
   assign MemWrite_o = ctrl_q.mem_write;
   assign MemtoReg_o = ctrl_q.mem_to_reg;
   assign ALUOp_o    = ctrl_q.alu_op;
   assign illegal_o  = ctrl_q.illegal;

endmodule
